muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multi-cycle responder that executes the MUL, DIV and REM ALU operations off the single-cycle ALU datapath. The core issues a request with operands and alu_op over a valid/ready handshake. The unit computes the result over WIDTH cycles and returns it over a second valid/ready handshake. This removes the combinational 32-bit multiplier and divider from the execute stage.

Parameters:
WIDTH, 32, operand and result width in bits; must be a power of two, at least 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  5  alu_op encoding from inst_pkg (MUL, DIV or REM)
req_a  input  WIDTH  operand A (multiplicand / dividend)
req_b  input  WIDTH  operand B (multiplier / divisor)
resp_valid  output  1  result present
resp_ready  input  1  consumer accepts result
resp_data  output  WIDTH  result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: the state goes to IDLE. req_ready=1, resp_valid=0, resp_data=0, busy=0, counter=0. Reset overrides all other activity, including an operation in BUSY or a result held in DONE; the in-flight result is discarded and no response is produced.
- Acceptance: a request is accepted in a cycle with req_valid && req_ready. req_ready is 1 only in IDLE. req_op, req_a and req_b are captured on that edge and need not remain stable afterwards.
- Arithmetic: all operations are unsigned, matching the ALU.
  - MUL returns the low WIDTH bits of a*b.
  - DIV returns floor(a/b).
  - REM returns a mod b.
- States are IDLE, BUSY and DONE.
- IDLE -> BUSY: on acceptance of MUL, or of DIV/REM with b!=0. The counter loads WIDTH.
- IDLE -> DONE (fast path): on acceptance of DIV/REM with b==0, or of any other op. The fast-path results are:
  - DIV with b==0: resp_data = all ones.
  - REM with b==0: resp_data = a.
  - Any other op: resp_data = 0, mirroring the ALU default.
- BUSY, MUL: shift-add, one multiplier bit per cycle, LSB first. The accumulator is WIDTH bits wide and the upper product bits are dropped.
- BUSY, DIV/REM: restoring division, one quotient bit per cycle, MSB first. It uses a WIDTH+1-bit partial remainder.
- BUSY -> DONE: when the counter reaches 1 on an edge. The result register is loaded on that same edge.
- Latency: in BUSY, resp_valid first goes high WIDTH cycles after the acceptance cycle. On the fast path, resp_valid goes high the cycle after acceptance.
- DONE: resp_valid=1 and resp_data is held stable until resp_valid && resp_ready.
  - On that edge the state returns to IDLE and resp_valid falls.
  - resp_data keeps its last value; it is only meaningful while resp_valid=1.
- No back-to-back overlap: a new request cannot be accepted in the same cycle a response is consumed. req_ready rises the cycle after the DONE->IDLE transition.
- Simultaneous rst and req_valid: reset wins and the request is not accepted.
- Operands equal to 0 or all ones need no special handling beyond divide-by-zero.

Decomposition:
- inst_pkg (shared, existing) provides the alu_op enum values MUL, DIV and REM. The unit imports it and defines no private op encodings.
- Add to inst_pkg: the muldiv_state_t enum (IDLE, BUSY, DONE).
- One sub-module is natural: muldiv_div_step. It is a combinational single iteration of restoring division: partial remainder, quotient, divisor in; next remainder and quotient out. The multiply step stays inline.

Test Plan:
- MUL a=7, b=6 -> resp_data=42; resp_valid first high 32 cycles after acceptance; busy high throughout.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> resp_data=0x00000001. Then DIV a=100, b=7 -> 14, and REM a=100, b=7 -> 2, issued back-to-back with resp_ready tied high.
- Divide by zero: DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; each with resp_valid high the cycle after acceptance.
- Backpressure: DIV a=0x80000000, b=3 with resp_ready low for 3 cycles after resp_valid rises. resp_data must stay 0x2AAAAAAA throughout, req_ready must stay 0, and exactly one response is consumed.
- Reset mid-operation: assert rst for 1 cycle at BUSY cycle 10 of a MUL. Next cycle: IDLE, req_ready=1, resp_valid=0, resp_data=0. A new MUL 3*4 then returns 12.
- Unsupported op: req_op=ADD, a=1, b=2 -> resp_data=0 the cycle after acceptance. req_valid high while busy is not accepted and req_ready stays 0.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared instruction/ALU encodings. Also holds the FSM state type for the
// iterative mul/div responder.
package inst_pkg;

    typedef enum logic [4:0] {
        ADD  = 5'd0,
        SUB  = 5'd1,
        SLL  = 5'd2,
        SLT  = 5'd3,
        SLTU = 5'd4,
        XOR  = 5'd5,
        SRL  = 5'd6,
        SRA  = 5'd7,
        OR   = 5'd8,
        AND  = 5'd9,
        MUL  = 5'd10,
        DIV  = 5'd11,
        REM  = 5'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the quotient bit in.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] part;
    logic           ge;

    // quo carries the unconsumed dividend bits at the top and quotient bits at the bottom
    assign part    = {rem, quo[WIDTH-1]};
    assign ge      = part >= {1'b0, dvsr};
    assign rem_nxt = ge ? (part[WIDTH-1:0] - dvsr) : part[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/DIV/REM responder, one bit per cycle, with
// valid/ready handshakes on both request and response.
module muldiv_unit
    import inst_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       op_q;
    // MUL: acc=partial product, opa=multiplicand, opb=multiplier
    // DIV/REM: acc=partial remainder, opa=divisor, opb=dividend/quotient
    logic [WIDTH-1:0] acc, opa, opb;

    logic             idle, in_mul, in_div, in_rem, go_iter;
    logic [4:0]       s_op;
    logic [WIDTH-1:0] s_acc, s_a, s_b;
    logic [WIDTH-1:0] mul_acc, mul_a, mul_b, div_rem, div_quo;
    logic [WIDTH-1:0] nxt_acc, nxt_a, nxt_b, fin, fast;

    assign idle       = (state == IDLE);
    assign req_ready  = idle;
    assign resp_valid = (state == DONE);
    assign busy       = !idle;

    assign in_mul  = (req_op == MUL);
    assign in_div  = (req_op == DIV);
    assign in_rem  = (req_op == REM);
    assign go_iter = in_mul || ((in_div || in_rem) && (req_b != '0));

    // The first iteration runs on the acceptance edge straight from the request
    // operands, so the datapath inputs are muxed between request and registers.
    assign s_op  = idle ? req_op : op_q;
    assign s_acc = idle ? '0 : acc;
    assign s_a   = idle ? (in_mul ? req_a : req_b) : opa;
    assign s_b   = idle ? (in_mul ? req_b : req_a) : opb;

    assign mul_acc = s_acc + (s_b[0] ? s_a : '0);
    assign mul_a   = {s_a[WIDTH-2:0], 1'b0};
    assign mul_b   = {1'b0, s_b[WIDTH-1:1]};

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem     (s_acc),
        .quo     (s_b),
        .dvsr    (s_a),
        .rem_nxt (div_rem),
        .quo_nxt (div_quo)
    );

    assign nxt_acc = (s_op == MUL) ? mul_acc : div_rem;
    assign nxt_a   = (s_op == MUL) ? mul_a   : s_a;
    assign nxt_b   = (s_op == MUL) ? mul_b   : div_quo;
    assign fin     = (s_op == MUL) ? mul_acc : ((s_op == DIV) ? div_quo : div_rem);

    always_comb begin
        fast = '0;
        if (in_div)      fast = '1;
        else if (in_rem) fast = req_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q <= req_op;
                    if (go_iter) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(WIDTH);
                        acc   <= nxt_acc;
                        opa   <= nxt_a;
                        opb   <= nxt_b;
                    end else begin
                        state     <= DONE;
                        resp_data <= fast;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    acc <= nxt_acc;
                    opa <= nxt_a;
                    opb <= nxt_b;
                    // counter reaching 1 on this edge means the WIDTH-th iteration just ran
                    if (cnt == CNT_W'(2)) begin
                        state     <= DONE;
                        resp_data <= fin;
                    end
                end
                DONE: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a scoreboard plus
// hand sequences for backpressure, reset mid-operation and busy rejection.
module tb_muldiv_unit;
    import inst_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1;
    logic         req_valid = 1'b0, resp_ready = 1'b1;
    logic [4:0]   req_op = '0;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic         req_ready, resp_valid, busy;
    logic [W-1:0] resp_data;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0, consumed = 0;

    typedef struct {
        logic [W-1:0] data;
        int           first;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a, b, exp;
        int           lat;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // response monitor / scoreboard
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                if (!prev_v) begin
                    tests++; fails++;
                    $display("FAIL spurious_resp: got data %h expected no response", resp_data);
                end
            end else begin
                if (!prev_v) begin
                    chk("latency", cyc, sb[0].first);
                    chk("req_ready_in_done", {31'b0, req_ready}, '0);
                end
                if (resp_ready) begin
                    chk("resp_data", resp_data, sb[0].data);
                    void'(sb.pop_front());
                    consumed++;
                end
            end
        end
        prev_v <= resp_valid;
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout: req_ready got 0 expected 1");
        end else begin
            req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
            @(posedge clk);
            #1;
            req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
            if (push) sb.push_back('{exp, cyc - 1 + lat});
        end
    endtask

    task automatic drain(input string nm);
        bit bad = 1'b0;
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            if (sb.size() != 0 && !busy) bad = 1'b1;
            n++;
        end
        chk({nm, "_busy_low"}, {31'b0, bad}, '0);
        chk({nm, "_timeout"}, {31'b0, sb.size() != 0}, '0);
    endtask

    initial begin
        tbl.push_back('{MUL, 32'd7,          32'd6,          32'd42,         32});
        tbl.push_back('{MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32});
        tbl.push_back('{DIV, 32'd100,        32'd7,          32'd14,         32});
        tbl.push_back('{REM, 32'd100,        32'd7,          32'd2,          32});
        tbl.push_back('{DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        tbl.push_back('{REM, 32'd5,          32'd0,          32'd5,          1});
        tbl.push_back('{ADD, 32'd1,          32'd2,          32'd0,          1});
        tbl.push_back('{MUL, 32'h1234_5678,  32'h10,         32'h2345_6780,  32});
        tbl.push_back('{DIV, 32'd0,          32'd5,          32'd0,          32});
        tbl.push_back('{DIV, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32});
        tbl.push_back('{REM, 32'hFFFF_FFFF,  32'h10,         32'hF,          32});
        tbl.push_back('{MUL, 32'd0,          32'hFFFF_FFFF,  32'd0,          32});

        // reset held with a request present: request must not be taken
        req_valid = 1'b1; req_op = MUL; req_a = 32'd3; req_b = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, '0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_busy", {31'b0, busy}, '0);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 1'b1);
            drain($sformatf("vec%0d", i));
        end

        // backpressure on a DIV result, with a request knocking while DONE
        begin
            int n = 0;
            int c0;
            @(posedge clk); #1; resp_ready = 1'b0;
            issue(DIV, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32, 1'b1);
            @(negedge clk);
            while (!resp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_timeout", {31'b0, resp_valid}, 32'd1);
            c0 = consumed;
            req_valid = 1'b1; req_op = ADD; req_a = 32'd9; req_b = 32'd9;
            for (int k = 0; k < 3; k++) begin
                if (k != 0) @(negedge clk);
                chk("bp_data_hold", resp_data, 32'h2AAA_AAAA);
                chk("bp_req_ready", {31'b0, req_ready}, '0);
            end
            @(posedge clk); #1;
            resp_ready = 1'b1; req_valid = 1'b0;
            repeat (4) @(negedge clk);
            chk("bp_one_consumed", consumed - c0, 32'd1);
            chk("bp_back_idle", {31'b0, req_ready}, 32'd1);
        end

        // request held high while busy is ignored
        begin
            bit seen = 1'b0;
            issue(MUL, 32'd5, 32'd5, 32'd25, 32, 1'b1);
            req_valid = 1'b1; req_op = ADD; req_a = 32'd1; req_b = 32'd2;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (req_ready) seen = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("busy_req_ready", {31'b0, seen}, '0);
            drain("busy_mul");
        end

        // reset in the 10th BUSY cycle of a MUL discards the result
        begin
            bit seen = 1'b0;
            issue(MUL, 32'hDEAD_BEEF, 32'h0000_1234, '0, 32, 1'b0);
            repeat (9) @(posedge clk);
            #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            @(negedge clk);
            chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
            chk("mid_rst_resp_valid", {31'b0, resp_valid}, '0);
            chk("mid_rst_resp_data", resp_data, '0);
            chk("mid_rst_busy", {31'b0, busy}, '0);
            repeat (40) begin
                @(negedge clk);
                if (resp_valid) seen = 1'b1;
            end
            chk("mid_rst_no_resp", {31'b0, seen}, '0);
            issue(MUL, 32'd3, 32'd4, 32'd12, 32, 1'b1);
            drain("post_rst_mul");
        end

        chk("sb_empty", sb.size(), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
